request_conditioner: RTL and testbench
======================================

# request_conditioner

Conditions the three active-low KEY request buttons before they reach `traffic_controller_fsm`, sitting between the board pins and the FSM's request inputs.
- Each button is synchronised, debounced, and converted from a level to a single press event.
- Each press is held in a sticky pending flag until the FSM acknowledges service, so short presses are never lost between light phases.
- Runs on the divided `clk` from `clock`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable `clk` cycles required to accept a level change; legal range ≥1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `reset`  input  1  synchronous, active-high; clears all state at the next edge.
- `not_southbound_left_request`  input  1  raw KEY, active low, asynchronous.
- `not_ns_walk_request`  input  1  raw KEY, active low, asynchronous.
- `not_ew_walk_request`  input  1  raw KEY, active low, asynchronous.
- `left_ack`  input  1  FSM pulse: left-turn phase entered; clears left pending.
- `walk_ack`  input  1  FSM pulse: walk phase entered; clears both walk pendings.
- `southbound_left_request`  output  1  left pending flag.
- `walk_request`  output  1  OR of the NS and EW walk pending flags.
- `pending`  output  3  `{ew, ns, left}` pending flags, for debug LEDs.

## Operation
Each channel runs the same pipeline: invert → 2-FF synchroniser → debouncer → press detect → pending latch.
- **Synchroniser:** `sync1 <= ~not_x`, `sync2 <= sync1`.
- **Debouncer state:** `stable` (accepted level) and `cnt`.
  - If `sync2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Any glitch back to `stable` before acceptance restarts the count.
- **Press event:** asserted in the cycle where `stable` flips 0→1. A release (1→0) produces no event.
- **Pending latch:**
  - Set on a press event.
  - Cleared on that channel's ack (`left_ack` for left; `walk_ack` for both ns and ew).
  - If a press event and an ack occur in the same cycle, set wins and the flag stays 1.
- **Holding and repeat presses:**
  - Holding a button yields exactly one request.
  - Re-arming requires a release, accepted for `DEBOUNCE_CYCLES`, followed by a new press.
  - Presses while the flag is already pending are absorbed; there is no counting.
- **Ack with nothing pending:** no effect.

## Timing
- **Reset values:** all synchroniser, `stable`, `cnt`, and pending registers are 0. Therefore `southbound_left_request = 0`, `walk_request = 0`, and `pending = 3'b000` after the reset edge.
- **Press latency:** raw input falls before edge k.
  - `sync2` = 1 after edge k+1.
  - `stable` and pending = 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - Outputs are registered; there is no combinational path from raw inputs.
- **Ack latency:** ack high at edge j → flag 0 after edge j (one cycle).
- **Reset mid-debounce:** the count is discarded.
- **Button held through reset:** synchroniser and `stable` restart at 0, so the held button is seen as a fresh press. Pending rises `DEBOUNCE_CYCLES+2` edges after reset deasserts.
- **Counter wrap:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, so it cannot wrap.

## Configuration
- **`REQUEST_CONDITIONER_DEBOUNCE_EN` defined:** the debouncer is built as described above.
- **`REQUEST_CONDITIONER_DEBOUNCE_EN` undefined:**
  - The debouncer is removed and `stable <= sync2` every cycle. This is identical to `DEBOUNCE_CYCLES = 1`.
  - Press latency is 2 edges after capture (pending = 1 after edge k+2).
  - `cnt` is absent.
  - Used for fast simulation and for the `debug` single-step build.

## Structure
- **Shared package `traffic_pkg`:**
  - `NUM_REQ = 3`.
  - Channel index constants `REQ_LEFT = 0`, `REQ_NS = 1`, `REQ_EW = 2`.
  - Typedef `req_vec_t` (`logic [NUM_REQ-1:0]`) for `pending`.
- **Sub-module `key_debouncer`:**
  - Ports: `clk`, `reset`, `not_key`, `press`.
  - Contains synchroniser, debouncer, and edge detect.
  - Instantiated once per channel.
- **Top level** holds only the three pending latches and the ack/OR logic.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- **Clean press:** drive `not_ns_walk_request` low before edge 10 and hold. `walk_request` = 0 through edge 14, = 1 after edge 15, and `pending = 3'b010`.
- **Glitch rejection:** 3-cycle low pulse on `not_southbound_left_request` → `southbound_left_request` stays 0 indefinitely and `cnt` returns to 0.
- **Ack with held button:**
  - With left pending and button still held, pulse `left_ack` for 1 cycle → flag 0 the next cycle and stays 0 while the button is held.
  - After release, a new press sets it again.
- **Simultaneous set/ack:** EW press event in the same cycle as `walk_ack`, with NS pending → NS cleared, EW remains 1, `walk_request` = 1.
- **Reset mid-operation:** with all three pending and NS mid-debounce, assert `reset` for 1 cycle → `pending = 3'b000` after that edge. With NS still held, NS re-asserts 6 edges after reset deasserts.
- **Macro undefined:** single-cycle-resolved press → pending = 1 exactly 2 edges after capture; a 1-cycle glitch of ≥1 full cycle is accepted.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light request path: request channel
// count, channel index constants and the request vector type.
package traffic_pkg;

    localparam int NUM_REQ  = 3;
    localparam int REQ_LEFT = 0;
    localparam int REQ_NS   = 1;
    localparam int REQ_EW   = 2;

    typedef logic [NUM_REQ-1:0] req_vec_t;

endpackage

// File: rtl/key_debouncer.sv
// One KEY channel: invert, 2-FF synchronise, debounce and emit a press event.
// Debouncer is built only when REQUEST_CONDITIONER_DEBOUNCE_EN is defined.
module key_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic not_key,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic stable_r;
    logic accept_s;

    if ((DEBOUNCE_CYCLES < 1) || ((2 ** CNT_W) < DEBOUNCE_CYCLES)) begin : g_bad_cfg
        $error("key_debouncer: DEBOUNCE_CYCLES must be >= 1 and fit in CNT_W bits");
    end

    // Two-flop synchroniser on the inverted, now active-high, key level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= ~not_key;
            sync2_r <= sync1_r;
        end
    end

`ifdef REQUEST_CONDITIONER_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // A new level is accepted on the last cycle of an unbroken run
    always_comb begin
        accept_s = (sync2_r != stable_r) && (cnt_r == CNT_LAST);
    end

    // Counter restarts whenever the input matches the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (sync2_r == stable_r) begin
            cnt_r    <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= sync2_r;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end
`else
    // Without the debouncer every synchronised change is accepted at once
    always_comb begin
        accept_s = (sync2_r != stable_r);
    end

    // Accepted level simply follows the synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_r <= 1'b0;
        end else begin
            stable_r <= sync2_r;
        end
    end
`endif

    // Event coincides with the edge where stable goes 0->1, so the
    // pending latch sets on that same edge
    always_comb begin
        press = accept_s & ~stable_r;
    end

endmodule

// File: rtl/request_conditioner.sv
// Conditions the three active-low KEY requests into sticky pending flags
// cleared by FSM acks. Debouncer enabled by REQUEST_CONDITIONER_DEBOUNCE_EN.
module request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     not_southbound_left_request,
    input  logic     not_ns_walk_request,
    input  logic     not_ew_walk_request,
    input  logic     left_ack,
    input  logic     walk_ack,
    output logic     southbound_left_request,
    output logic     walk_request,
    output req_vec_t pending
);

    req_vec_t press_s;
    req_vec_t clear_s;
    req_vec_t pending_r;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
        .clk     (clk),
        .reset   (reset),
        .not_key (not_southbound_left_request),
        .press   (press_s[REQ_LEFT])
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ns (
        .clk     (clk),
        .reset   (reset),
        .not_key (not_ns_walk_request),
        .press   (press_s[REQ_NS])
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ew (
        .clk     (clk),
        .reset   (reset),
        .not_key (not_ew_walk_request),
        .press   (press_s[REQ_EW])
    );

    // Map acks onto channels: one walk ack serves both walk buttons
    always_comb begin
        clear_s           = {NUM_REQ{1'b0}};
        clear_s[REQ_LEFT] = left_ack;
        clear_s[REQ_NS]   = walk_ack;
        clear_s[REQ_EW]   = walk_ack;
    end

    // Sticky pending flags; a press in the ack cycle wins over the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r <= {NUM_REQ{1'b0}};
        end else begin
            pending_r <= press_s | (pending_r & ~clear_s);
        end
    end

    assign pending                 = pending_r;
    assign southbound_left_request = pending_r[REQ_LEFT];
    assign walk_request            = pending_r[REQ_NS] | pending_r[REQ_EW];

endmodule

// File: tb/tb_request_conditioner.sv
// Self-checking bench for request_conditioner: directed scenarios plus random
// key traffic checked every cycle against a history-window reference model.
module tb_request_conditioner;

    localparam int DEB = 4;
`ifdef REQUEST_CONDITIONER_DEBOUNCE_EN
    localparam int EFF = DEB;
`else
    localparam int EFF = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       not_left;
    logic       not_ns;
    logic       not_ew;
    logic       left_ack;
    logic       walk_ack;
    logic       sbl_req;
    logic       walk_req;
    logic [2:0] pending;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: per-channel history of sampled pressed levels,
    // bit i = level sampled i+1 edges before the edge being evaluated
    logic [63:0] hist [3];
    logic [2:0]  m_stab;
    logic [2:0]  m_pend;

    request_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .not_southbound_left_request (not_left),
        .not_ns_walk_request         (not_ns),
        .not_ew_walk_request         (not_ew),
        .left_ack                    (left_ack),
        .walk_ack                    (walk_ack),
        .southbound_left_request     (sbl_req),
        .walk_request                (walk_req),
        .pending                     (pending)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // A level change is accepted once the synchronised input (two edges old)
    // has shown the other level for EFF consecutive edges.
    task automatic model_edge();
        logic [2:0] p;
        logic [2:0] ev;
        logic [2:0] clr;
        logic       all_diff;
        p   = ~{not_ew, not_ns, not_left};
        clr = {walk_ack, walk_ack, left_ack};
        if (reset) begin
            for (int c = 0; c < 3; c++) hist[c] = 64'd0;
            m_stab = 3'b000;
            m_pend = 3'b000;
        end else begin
            ev = 3'b000;
            for (int c = 0; c < 3; c++) begin
                all_diff = 1'b1;
                for (int i = 1; i <= EFF; i++)
                    if (hist[c][i] == m_stab[c]) all_diff = 1'b0;
                if (all_diff) begin
                    if (!m_stab[c]) ev[c] = 1'b1;
                    m_stab[c] = ~m_stab[c];
                end
                hist[c] = {hist[c][62:0], p[c]};
            end
            m_pend = ev | (m_pend & ~clr);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check3("model_pending", pending, m_pend);
            check1("model_left", sbl_req, m_pend[0]);
            check1("model_walk", walk_req, m_pend[1] | m_pend[2]);
        end
    endtask

    initial begin
        int         run [3];
        logic [2:0] lvl;
        for (int c = 0; c < 3; c++) hist[c] = 64'd0;
        m_stab   = 3'b000;
        m_pend   = 3'b000;
        reset    = 1'b1;
        not_left = 1'b1;
        not_ns   = 1'b1;
        not_ew   = 1'b1;
        left_ack = 1'b0;
        walk_ack = 1'b0;
        @(negedge clk);

        // Reset state
        tick(2);
        reset = 1'b0;
        check3("reset_pending", pending, 3'b000);
        check1("reset_left", sbl_req, 1'b0);
        check1("reset_walk", walk_req, 1'b0);

        // Clean NS press: nothing until edge k+1+EFF
        not_ns = 1'b0;
        tick(EFF + 1);
        check1("clean_early", walk_req, 1'b0);
        tick(1);
        check1("clean_walk", walk_req, 1'b1);
        check3("clean_pending", pending, 3'b010);

        // Walk ack with NS still held: cleared and not re-raised
        walk_ack = 1'b1;
        tick(1);
        walk_ack = 1'b0;
        check3("ack_clear", pending, 3'b000);
        tick(4);
        check1("ack_held", walk_req, 1'b0);
        not_ns = 1'b1;
        tick(EFF + 3);

`ifdef REQUEST_CONDITIONER_DEBOUNCE_EN
        // Short glitch is rejected and the counter returns to zero
        not_left = 1'b0;
        tick(3);
        not_left = 1'b1;
        tick(6);
        check1("glitch_left", sbl_req, 1'b0);
        check1("glitch_cnt", dut.u_left.cnt_r === 3'd0, 1'b1);
`else
        // Without debounce a one-cycle press lands exactly two edges later
        not_left = 1'b0;
        tick(1);
        not_left = 1'b1;
        tick(1);
        check1("fast_early", sbl_req, 1'b0);
        tick(1);
        check1("fast_left", sbl_req, 1'b1);
        left_ack = 1'b1;
        tick(1);
        left_ack = 1'b0;
        check1("fast_ack", sbl_req, 1'b0);
`endif
        tick(EFF + 3);

        // Left ack with button held, then re-arm via release and new press
        not_left = 1'b0;
        tick(EFF + 2);
        check1("held_set", sbl_req, 1'b1);
        left_ack = 1'b1;
        tick(1);
        left_ack = 1'b0;
        check1("held_ack", sbl_req, 1'b0);
        tick(5);
        check1("held_stay", sbl_req, 1'b0);
        not_left = 1'b1;
        tick(EFF + 3);
        not_left = 1'b0;
        tick(EFF + 2);
        check1("rearm_left", sbl_req, 1'b1);
        not_left = 1'b1;
        left_ack = 1'b1;
        tick(1);
        left_ack = 1'b0;
        tick(EFF + 3);

        // EW press event in the same cycle as walk_ack with NS pending
        not_ns = 1'b0;
        tick(EFF + 2);
        check3("sim_ns", pending, 3'b010);
        not_ew = 1'b0;
        tick(EFF + 1);
        check3("sim_pre", pending, 3'b010);
        walk_ack = 1'b1;
        tick(1);
        walk_ack = 1'b0;
        check3("sim_pending", pending, 3'b100);
        check1("sim_walk", walk_req, 1'b1);
        not_ns   = 1'b1;
        not_ew   = 1'b1;
        walk_ack = 1'b1;
        tick(1);
        walk_ack = 1'b0;
        tick(EFF + 3);

        // Reset with all pending and NS mid-debounce; held NS re-asserts
        not_left = 1'b0;
        not_ns   = 1'b0;
        not_ew   = 1'b0;
        tick(EFF + 2);
        check3("all_pending", pending, 3'b111);
        not_ns = 1'b1;
        tick(EFF + 3);
        not_ns = 1'b0;
        tick(2);
        reset    = 1'b1;
        not_left = 1'b1;
        not_ew   = 1'b1;
        tick(1);
        reset = 1'b0;
        check3("rst_clear", pending, 3'b000);
        tick(EFF + 1);
        check3("rst_early", pending, 3'b000);
        tick(1);
        check3("rst_reassert", pending, 3'b010);
        not_ns   = 1'b1;
        walk_ack = 1'b1;
        tick(1);
        walk_ack = 1'b0;
        tick(EFF + 3);

        // Random key traffic with random runs, acks and occasional reset
        lvl = 3'b000;
        for (int c = 0; c < 3; c++) run[c] = 1;
        for (int t = 0; t < 500; t++) begin
            for (int c = 0; c < 3; c++) begin
                run[c]--;
                if (run[c] <= 0) begin
                    lvl[c] = ~lvl[c];
                    run[c] = int'($urandom_range(1, 9));
                end
            end
            not_left = ~lvl[0];
            not_ns   = ~lvl[1];
            not_ew   = ~lvl[2];
            left_ack = ($urandom_range(0, 5) == 0);
            walk_ack = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        reset    = 1'b0;
        left_ack = 1'b0;
        walk_ack = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
